// File: rtl/fft_pkg.sv
// Shared constants and types for the FFT peak detector: frame geometry,
// sample field positions and the per-sample tag that travels down the pipeline.
package fft_pkg;

  localparam int POINTS   = 64;
  localparam int DATA_W   = 16;
  localparam int BIN_W    = $clog2(POINTS);
  localparam int SAMPLE_W = 2 * DATA_W;
  localparam int MAG_W    = 2 * DATA_W;

  // In_Stream packing: real in the upper half, imaginary in the lower half
  localparam int RE_MSB = SAMPLE_W - 1;
  localparam int RE_LSB = DATA_W;
  localparam int IM_MSB = DATA_W - 1;
  localparam int IM_LSB = 0;

  typedef logic [MAG_W-1:0] mag_t;
  typedef logic [BIN_W-1:0] bin_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    bin_t bin;
  } tag_t;

endpackage

// File: rtl/fft_mag_sq.sv
// Two-stage magnitude-squared pipeline: stage 1 squares both components,
// stage 2 sums them; the sample tag rides alongside each stage.
module fft_mag_sq
  import fft_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sample_i,
  input  tag_t                tag_i,
  output mag_t                mag_o,
  output tag_t                tag_o,
  output logic                busy_o
);

  logic signed [DATA_W-1:0] re, im;
  logic signed [MAG_W-1:0]  re_sq_q, re_sq_d;
  logic signed [MAG_W-1:0]  im_sq_q, im_sq_d;
  mag_t                     mag_q, mag_d;
  tag_t                     tag1_q, tag2_q;

  // Each square is at most 2^30, so the unsigned sum tops out at 2^31 in 32 bits.
  always_comb begin
    re      = sample_i[RE_MSB:RE_LSB];
    im      = sample_i[IM_MSB:IM_LSB];
    re_sq_d = re * re;
    im_sq_d = im * im;
    mag_d   = $unsigned(re_sq_q) + $unsigned(im_sq_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      re_sq_q <= '0;
      im_sq_q <= '0;
      mag_q   <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
    end else begin
      tag1_q <= tag_i;
      tag2_q <= tag1_q;
      if (tag_i.valid) begin
        re_sq_q <= re_sq_d;
        im_sq_q <= im_sq_d;
      end
      if (tag1_q.valid) begin
        mag_q <= mag_d;
      end
    end
  end

  assign mag_o  = mag_q;
  assign tag_o  = tag2_q;
  assign busy_o = tag1_q.valid | tag2_q.valid;

endmodule

// File: rtl/fft_peak_detector.sv
// Per-frame peak finder for a streaming FFT: tags samples with their bin,
// tracks the largest |X|^2 and hands the result off with a valid/ready pair.
module fft_peak_detector #(
  parameter int POINTS = fft_pkg::POINTS,
  parameter int DATA_W = fft_pkg::DATA_W,
  parameter int BIN_W  = fft_pkg::BIN_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2*DATA_W-1:0] In_Stream,
  input  logic                Data_In,
  output logic [2*DATA_W-1:0] Peak_Mag,
  output logic [BIN_W-1:0]    Peak_Bin,
  output logic                Peak_Valid,
  input  logic                Peak_Ready,
  output logic                Frame_Overrun,
  output logic                Busy
);

  fft_pkg::tag_t       tag_in, tag2;
  logic [2*DATA_W-1:0] mag2;
  logic                mag_busy;

  logic [BIN_W-1:0]    bin_q, bin_d;
  logic [2*DATA_W-1:0] run_max_q, run_max_d;
  logic [BIN_W-1:0]    run_bin_q, run_bin_d;
  logic                done_q, done_d;
  logic [2*DATA_W-1:0] peak_mag_q, peak_mag_d;
  logic [BIN_W-1:0]    peak_bin_q, peak_bin_d;
  logic                peak_valid_q, peak_valid_d;
  logic                overrun_q, overrun_d;
  logic                hs;

  fft_mag_sq u_mag_sq (
    .clk      (clk),
    .rst      (rst),
    .sample_i (In_Stream),
    .tag_i    (tag_in),
    .mag_o    (mag2),
    .tag_o    (tag2),
    .busy_o   (mag_busy)
  );

  always_comb begin
    tag_in       = '0;
    tag_in.valid = Data_In;
    tag_in.bin   = bin_q;
    tag_in.first = (bin_q == '0);
    tag_in.last  = (bin_q == BIN_W'(POINTS - 1));

    bin_d = bin_q;
    if (Data_In) begin
      bin_d = tag_in.last ? '0 : bin_q + 1'b1;
    end

    // Strict compare keeps the lowest bin on ties; first sample always seeds.
    run_max_d = run_max_q;
    run_bin_d = run_bin_q;
    if (tag2.valid && (tag2.first || (mag2 > run_max_q))) begin
      run_max_d = mag2;
      run_bin_d = tag2.bin;
    end
    done_d = tag2.valid && tag2.last;

    // done_q reads run_max_q before the next frame's bin 0 reseeds it.
    hs           = peak_valid_q && Peak_Ready;
    peak_mag_d   = peak_mag_q;
    peak_bin_d   = peak_bin_q;
    peak_valid_d = hs ? 1'b0 : peak_valid_q;
    overrun_d    = overrun_q;
    if (done_q) begin
      peak_mag_d   = run_max_q;
      peak_bin_d   = run_bin_q;
      peak_valid_d = 1'b1;
      if (peak_valid_q && !Peak_Ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q        <= '0;
      run_max_q    <= '0;
      run_bin_q    <= '0;
      done_q       <= 1'b0;
      peak_mag_q   <= '0;
      peak_bin_q   <= '0;
      peak_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      bin_q        <= bin_d;
      run_max_q    <= run_max_d;
      run_bin_q    <= run_bin_d;
      done_q       <= done_d;
      peak_mag_q   <= peak_mag_d;
      peak_bin_q   <= peak_bin_d;
      peak_valid_q <= peak_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign Peak_Mag      = peak_mag_q;
  assign Peak_Bin      = peak_bin_q;
  assign Peak_Valid    = peak_valid_q;
  assign Frame_Overrun = overrun_q;
  assign Busy          = (bin_q != '0) | mag_busy | done_q;

endmodule

// File: tb/tb_fft_peak_detector.sv
// Self-checking bench for fft_peak_detector: frame results are predicted
// into a queue at the last sample and compared when the DUT hands them off.
module tb_fft_peak_detector;
  import fft_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] In_Stream;
  logic        Data_In;
  logic [31:0] Peak_Mag;
  logic [5:0]  Peak_Bin;
  logic        Peak_Valid;
  logic        Peak_Ready;
  logic        Frame_Overrun;
  logic        Busy;

  fft_peak_detector dut (
    .clk           (clk),
    .rst           (rst),
    .In_Stream     (In_Stream),
    .Data_In       (Data_In),
    .Peak_Mag      (Peak_Mag),
    .Peak_Bin      (Peak_Bin),
    .Peak_Valid    (Peak_Valid),
    .Peak_Ready    (Peak_Ready),
    .Frame_Overrun (Frame_Overrun),
    .Busy          (Busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] mag;
    logic [5:0]  bin;
    int          at;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  logic        mon_en = 1'b0;
  logic [31:0] frame_mem [POINTS];

  // Result is due 4 negedges after the negedge that drove sample 63.
  always @(negedge clk) begin
    if (mon_en && Peak_Valid && Peak_Ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result: got mag=%0d bin=%0d at cyc %0d, required no result", Peak_Mag, Peak_Bin, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (Peak_Mag !== mon_e.mag || Peak_Bin !== mon_e.bin || cyc !== mon_e.at) begin
          failures++;
          $display("FAIL frame_result: got mag=%0d bin=%0d cyc=%0d, required mag=%0d bin=%0d cyc=%0d",
                   Peak_Mag, Peak_Bin, cyc, mon_e.mag, mon_e.bin, mon_e.at);
        end
      end
    end
  end

  function automatic logic [31:0] mk(input int re, input int im);
    logic [31:0] s;
    s[31:16] = re[15:0];
    s[15:0]  = im[15:0];
    return s;
  endfunction

  task automatic clear_frame();
    for (int i = 0; i < POINTS; i++) frame_mem[i] = '0;
  endtask

  task automatic fill_noise(input int amp);
    for (int i = 0; i < POINTS; i++)
      frame_mem[i] = mk(int'($urandom_range(0, 2 * amp)) - amp, int'($urandom_range(0, 2 * amp)) - amp);
  endtask

  task automatic model(output logic [31:0] m, output logic [5:0] b);
    longint best, re, im, mg;
    best = -1;
    m = '0;
    b = '0;
    for (int i = 0; i < POINTS; i++) begin
      re = longint'($signed(frame_mem[i][31:16]));
      im = longint'($signed(frame_mem[i][15:0]));
      mg = re * re + im * im;
      if (mg > best) begin
        best = mg;
        m    = mg[31:0];
        b    = 6'(i);
      end
    end
  endtask

  task automatic send_frame(input bit gaps, input int n, output int last_cyc);
    last_cyc = 0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          Data_In = 1'b0;
        end
      end
      @(negedge clk);
      Data_In   = 1'b1;
      In_Stream = frame_mem[i];
      if (i == POINTS - 1) last_cyc = cyc;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      Data_In = 1'b0;
    end
  endtask

  task automatic expect_frame(input logic [31:0] m, input logic [5:0] b, input int last_cyc);
    exp_t e;
    e.mag = m;
    e.bin = b;
    e.at  = last_cyc + 4;
    sb.push_back(e);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      Data_In = 1'b0;
      n++;
    end
    idle(8);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain_timeout: %0d results still pending, required 0", sb.size());
      sb.delete();
    end
    checks++;
    if (Busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_idle: got %b, required 0", Busy);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    checks++;
    if (Peak_Valid !== 1'b0 || Peak_Mag !== 32'd0 || Peak_Bin !== 6'd0 || Frame_Overrun !== 1'b0 || Busy !== 1'b0) begin
      failures++;
      $display("FAIL %s: got valid=%b mag=%0d bin=%0d ovr=%b busy=%b, required all 0",
               tag, Peak_Valid, Peak_Mag, Peak_Bin, Frame_Overrun, Busy);
    end
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    Data_In    = 1'b1;
    In_Stream  = mk(5, 5);
    Peak_Ready = 1'b1;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset_state");
    rst     = 1'b0;
    Data_In = 1'b0;
    idle(2);
    mon_en = 1'b1;
  endtask

  task automatic test_single_peak();
    int lc;
    clear_frame();
    frame_mem[17] = mk(100, -200);
    send_frame(1'b0, POINTS, lc);
    expect_frame(32'd50000, 6'd17, lc);
    idle(1);
    checks++;
    if (Busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_inflight: got %b, required 1", Busy);
    end
    wait_drain();
  endtask

  task automatic test_tie();
    int lc;
    clear_frame();
    frame_mem[5]  = mk(300, 400);
    frame_mem[40] = mk(300, 400);
    send_frame(1'b0, POINTS, lc);
    expect_frame(32'd250000, 6'd5, lc);
    wait_drain();
  endtask

  task automatic test_extreme_gaps();
    int lc;
    fill_noise(1000);
    frame_mem[63] = mk(-32768, -32768);
    send_frame(1'b1, POINTS, lc);
    expect_frame(32'h8000_0000, 6'd63, lc);
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int lc;
    logic [31:0] m;
    logic [5:0]  b;
    int amps[3] = '{20000, 300, 5000};
    for (int f = 0; f < 3; f++) begin
      fill_noise(amps[f]);
      model(m, b);
      send_frame(1'b0, POINTS, lc);
      expect_frame(m, b, lc);
    end
    wait_drain();
  endtask

  task automatic test_mid_reset();
    int lc;
    fill_noise(100);
    frame_mem[10] = mk(20000, 20000);
    send_frame(1'b0, 30, lc);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero_outputs("mid_reset_outputs");
    rst     = 1'b0;
    Data_In = 1'b0;
    clear_frame();
    frame_mem[2] = mk(-700, 50);
    send_frame(1'b0, POINTS, lc);
    expect_frame(32'd492500, 6'd2, lc);
    wait_drain();
  endtask

  task automatic run_two_frames(output int lc);
    int lca;
    clear_frame();
    frame_mem[3] = mk(1000, 0);
    send_frame(1'b0, POINTS, lca);
    clear_frame();
    frame_mem[60] = mk(0, -2000);
    send_frame(1'b0, POINTS, lc);
    idle(3);
  endtask

  task automatic test_overrun();
    int lc;
    mon_en     = 1'b0;
    Peak_Ready = 1'b0;
    run_two_frames(lc);
    checks++;
    if (Peak_Valid !== 1'b1 || Peak_Bin !== 6'd3 || Peak_Mag !== 32'd1000000 || Frame_Overrun !== 1'b0) begin
      failures++;
      $display("FAIL first_held: got valid=%b bin=%0d mag=%0d ovr=%b, required 1/3/1000000/0", Peak_Valid, Peak_Bin, Peak_Mag, Frame_Overrun);
    end
    @(negedge clk);
    checks++;
    if (Peak_Valid !== 1'b1 || Peak_Bin !== 6'd60 || Peak_Mag !== 32'd4000000 || Frame_Overrun !== 1'b1) begin
      failures++;
      $display("FAIL overwrite: got valid=%b bin=%0d mag=%0d ovr=%b, required 1/60/4000000/1", Peak_Valid, Peak_Bin, Peak_Mag, Frame_Overrun);
    end
    Peak_Ready = 1'b1;
    @(negedge clk);
    Peak_Ready = 1'b0;
    checks++;
    if (Peak_Valid !== 1'b0 || Frame_Overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_sticky: got valid=%b ovr=%b, required 0/1", Peak_Valid, Frame_Overrun);
    end
    idle(4);
    checks++;
    if (Frame_Overrun !== 1'b1) begin
      failures++;
      $display("FAIL overrun_hold: got %b, required 1", Frame_Overrun);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (Frame_Overrun !== 1'b0) begin
      failures++;
      $display("FAIL overrun_reset: got %b, required 0", Frame_Overrun);
    end

    run_two_frames(lc);
    Peak_Ready = 1'b1;
    @(negedge clk);
    checks++;
    if (Peak_Valid !== 1'b1 || Peak_Bin !== 6'd60 || Peak_Mag !== 32'd4000000 || Frame_Overrun !== 1'b0) begin
      failures++;
      $display("FAIL load_on_handshake: got valid=%b bin=%0d mag=%0d ovr=%b, required 1/60/4000000/0", Peak_Valid, Peak_Bin, Peak_Mag, Frame_Overrun);
    end
    @(negedge clk);
    checks++;
    if (Peak_Valid !== 1'b0 || Frame_Overrun !== 1'b0) begin
      failures++;
      $display("FAIL handshake_clear: got valid=%b ovr=%b, required 0/0", Peak_Valid, Frame_Overrun);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_peak();
    test_tie();
    test_extreme_gaps();
    test_back_to_back();
    test_mid_reset();
    test_overrun();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
